// File: rtl/vga_timing_pkg.sv
// Shared 1024x768@60 timing constants, coordinate widths and receiver FSM
// state encoding. Also used by the display timing generator.
package vga_timing_pkg;

    // Horizontal timing in pixel strobes
    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_H_FP     = 24;
    localparam int XGA_H_SYNC   = 136;
    localparam int XGA_H_BP     = 160;
    localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;
    localparam int XGA_HS_START = XGA_H_ACTIVE + XGA_H_FP;

    // Vertical timing in lines
    localparam int XGA_V_ACTIVE = 768;
    localparam int XGA_V_FP     = 3;
    localparam int XGA_V_SYNC   = 6;
    localparam int XGA_V_BP     = 29;
    localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;
    localparam int XGA_VS_START = XGA_V_ACTIVE + XGA_V_FP;

    // Both syncs are active-low in this mode
    localparam int XGA_SYNC_POL = 0;

    // Coordinate widths
    localparam int X_W = 11;
    localparam int Y_W = 10;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Strobe-qualified leading-edge detector for one sync line. The history
// register only advances on strobe cycles, so activity between strobes is
// invisible to the detector.
module sync_edge_det #(
    parameter bit POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic sync,
    output logic lead
);

    logic sync_p0;

    // Remember the sync level seen on the previous strobe; reset to idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= ~POL;
        end else if (stb) begin
            sync_p0 <= sync;
        end
    end

    assign lead = stb && (sync == POL) && (sync_p0 != POL);

endmodule

// File: rtl/vga_timing_rx.sv
// Receive side of the VGA timing link: locks onto an HS/VS pair, measures
// line length and lines per frame, and regenerates pixel coordinates and
// display-enable. All state advances only on pixel-strobe cycles.
module vga_timing_rx
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = XGA_H_ACTIVE,
    parameter int H_TOTAL     = XGA_H_TOTAL,
    parameter int HS_START    = XGA_HS_START,
    parameter int V_ACTIVE    = XGA_V_ACTIVE,
    parameter int V_TOTAL     = XGA_V_TOTAL,
    parameter int VS_START    = XGA_VS_START,
    parameter int SYNC_POL    = XGA_SYNC_POL,
    parameter int LOCK_FRAMES = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_pix_stb,
    input  logic           i_hs,
    input  logic           i_vs,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_de,
    output logic           o_locked,
    output logic [X_W-1:0] o_line_len,
    output logic [Y_W-1:0] o_frame_lines,
    output logic           o_err
);

    // Timeout is twice a nominal line; its counter is sized separately from
    // lcnt because 2*H_TOTAL can exceed the 11-bit saturating line counter.
    localparam int TO_LIM = 2 * H_TOTAL;
    localparam int TO_W   = $clog2(TO_LIM + 1);
    localparam int G_W    = $clog2(LOCK_FRAMES + 1);

    localparam logic [X_W-1:0]  HTOT_M1  = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0]  HTOT     = X_W'(H_TOTAL);
    localparam logic [X_W-1:0]  HS_LOAD  = X_W'(HS_START);
    localparam logic [X_W-1:0]  HS_PRE   = X_W'(HS_START - 1);
    localparam logic [X_W-1:0]  X_ACT    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]  VTOT_M1  = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0]  VTOT     = Y_W'(V_TOTAL);
    localparam logic [Y_W-1:0]  VS_LOAD  = Y_W'(VS_START);
    localparam logic [Y_W-1:0]  VS_PRE   = Y_W'(VS_START - 1);
    localparam logic [Y_W-1:0]  Y_ACT    = Y_W'(V_ACTIVE);
    localparam logic [TO_W-1:0] TO_M1    = TO_W'(TO_LIM - 1);
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TO_LIM);
    localparam logic [G_W-1:0]  GOOD_M1  = G_W'(LOCK_FRAMES - 1);

    // Saturating increments for the measurement counters
    function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
        return (v == '1) ? v : v + X_W'(1);
    endfunction

    function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
        return (v == '1) ? v : v + Y_W'(1);
    endfunction

    logic            hs_lead;
    logic            vs_lead;
    logic [X_W-1:0]  hc;
    logic [Y_W-1:0]  vc;
    logic [X_W-1:0]  hc_nxt;
    logic [Y_W-1:0]  vc_nxt;
    logic [X_W-1:0]  lcnt;
    logic [Y_W-1:0]  fcnt;
    logic [TO_W-1:0] tcnt;
    logic [G_W-1:0]  gcnt;
    logic            bad;
    rx_state_e       state;

    logic [X_W-1:0]  line_len_new;
    logic            line_bad;
    logic [Y_W-1:0]  fcnt_hs;
    logic            to_hit;
    logic            hs_err;
    logic            vs_err;

    sync_edge_det #(.POL(SYNC_POL != 0)) u_hs_det (
        .clk  (i_clk),
        .rst  (i_rst),
        .stb  (i_pix_stb),
        .sync (i_hs),
        .lead (hs_lead)
    );

    sync_edge_det #(.POL(SYNC_POL != 0)) u_vs_det (
        .clk  (i_clk),
        .rst  (i_rst),
        .stb  (i_pix_stb),
        .sync (i_vs),
        .lead (vs_lead)
    );

    // HS/VS on the same strobe: the HS line is measured and counted first,
    // so the closing VS sees fcnt already including that edge.
    assign line_len_new = sat_inc_x(lcnt);
    assign line_bad     = (line_len_new != HTOT);
    assign fcnt_hs      = hs_lead ? sat_inc_y(fcnt) : fcnt;
    assign to_hit       = !hs_lead && (tcnt == TO_M1);
    assign hs_err       = hs_lead && (hc != HS_PRE);
    assign vs_err       = vs_lead && ((vc != VS_PRE) || (hc != HTOT_M1));

    // Next pixel coordinates: sync edges re-phase the counters, otherwise free-run
    always_comb begin
        hc_nxt = hc;
        vc_nxt = vc;
        if (hs_lead) begin
            hc_nxt = HS_LOAD;
        end else if (hc == HTOT_M1) begin
            hc_nxt = '0;
        end else begin
            hc_nxt = hc + X_W'(1);
        end
        if (vs_lead) begin
            vc_nxt = VS_LOAD;
        end else if (!hs_lead && (hc == HTOT_M1)) begin
            vc_nxt = (vc == VTOT_M1) ? '0 : vc + Y_W'(1);
        end
    end

    // Coordinate, measurement and lock FSM state, advanced only on strobes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hc            <= '0;
            vc            <= '0;
            lcnt          <= '0;
            fcnt          <= '0;
            tcnt          <= '0;
            gcnt          <= '0;
            bad           <= 1'b0;
            state         <= SEARCH;
            o_locked      <= 1'b0;
            o_err         <= 1'b0;
            o_line_len    <= '0;
            o_frame_lines <= '0;
        end else begin
            o_err <= 1'b0;
            if (i_pix_stb) begin
                hc <= hc_nxt;
                vc <= vc_nxt;

                if (hs_lead) begin
                    o_line_len <= line_len_new;
                    lcnt       <= '0;
                    tcnt       <= '0;
                end else begin
                    lcnt <= sat_inc_x(lcnt);
                    if (tcnt != TO_MAX) begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end

                if (vs_lead) begin
                    o_frame_lines <= fcnt_hs;
                    fcnt          <= '0;
                end else begin
                    fcnt <= fcnt_hs;
                end

                if (to_hit) begin
                    state    <= SEARCH;
                    o_locked <= 1'b0;
                    o_err    <= (state == LOCKED);
                end else begin
                    case (state)
                        SEARCH: begin
                            if (vs_lead) begin
                                state <= MEASURE;
                                gcnt  <= '0;
                                bad   <= 1'b0;
                            end
                        end
                        MEASURE: begin
                            if (vs_lead) begin
                                if (!bad && !(hs_lead && line_bad) && (fcnt_hs == VTOT)) begin
                                    gcnt <= gcnt + G_W'(1);
                                    if (gcnt == GOOD_M1) begin
                                        state    <= LOCKED;
                                        o_locked <= 1'b1;
                                    end
                                end else begin
                                    gcnt <= '0;
                                end
                                bad <= 1'b0;
                            end else if (hs_lead && line_bad) begin
                                bad <= 1'b1;
                            end
                        end
                        LOCKED: begin
                            // A VS edge starts a fresh frame; an HS slip leaves a partial one
                            if (hs_err || vs_err) begin
                                o_err    <= 1'b1;
                                o_locked <= 1'b0;
                                state    <= MEASURE;
                                gcnt     <= '0;
                                bad      <= !vs_lead;
                            end
                        end
                        default: begin
                            state    <= SEARCH;
                            o_locked <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign o_x  = hc;
    assign o_y  = vc;
    assign o_de = o_locked && (hc < X_ACT) && (vc < Y_ACT);

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx using a scaled-down raster (24x12 total,
// 16x8 active) so that many frames fit in a short run.
module tb_vga_timing_rx;

    localparam int HA  = 16;
    localparam int HT  = 24;
    localparam int HSS = 18;
    localparam int HSE = 22;
    localparam int VA  = 8;
    localparam int VT  = 12;
    localparam int VSS = 9;
    localparam int VSE = 11;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_pix_stb;
    logic        i_hs;
    logic        i_vs;
    logic [10:0] o_x;
    logic [9:0]  o_y;
    logic        o_de;
    logic        o_locked;
    logic [10:0] o_line_len;
    logic [9:0]  o_frame_lines;
    logic        o_err;

    int n_checks   = 0;
    int n_errors   = 0;
    int acc        = 0;
    int cur_f      = 0;
    int cur_x      = 0;
    int cur_y      = 0;
    int de_cnt     = 0;
    int de_bad     = 0;
    int coord_bad  = 0;
    int err_cycles = 0;
    int lock_pos   = -1;
    bit locked_q   = 1'b0;
    bit chk_coord  = 1'b1;

    vga_timing_rx #(
        .H_ACTIVE    (HA),
        .H_TOTAL     (HT),
        .HS_START    (HSS),
        .V_ACTIVE    (VA),
        .V_TOTAL     (VT),
        .VS_START    (VSS),
        .SYNC_POL    (0),
        .LOCK_FRAMES (2)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_pix_stb     (i_pix_stb),
        .i_hs          (i_hs),
        .i_vs          (i_vs),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_de          (o_de),
        .o_locked      (o_locked),
        .o_line_len    (o_line_len),
        .o_frame_lines (o_frame_lines),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    // o_err is counted per clock so a stretched pulse shows up as extra counts
    always @(negedge clk) begin
        if (o_err) err_cycles++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One pixel at a 65/100 strobe rate; outputs sampled on the following negedge
    task automatic send_px(input logic h, input logic v);
        i_hs = h;
        i_vs = v;
        acc += 65;
        while (acc < 100) begin
            i_pix_stb = 1'b0;
            @(negedge clk);
            acc += 65;
        end
        acc -= 100;
        i_pix_stb = 1'b1;
        @(negedge clk);
        i_pix_stb = 1'b0;
        if (o_de) de_cnt++;
        if (o_de && !o_locked) de_bad++;
        if (o_locked && chk_coord && ((int'(o_x) != cur_x) || (int'(o_y) != cur_y))) coord_bad++;
        if (o_locked && !locked_q) lock_pos = cur_f * 10000 + cur_y * 100 + cur_x;
        locked_q = o_locked;
    endtask

    // Active-low syncs; shift delays the HS leading edge by that many pixels
    task automatic run_line(input int y, input int shift, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            cur_x = x;
            cur_y = y;
            send_px(!((x >= HSS + shift) && (x < HSE)), !((y >= VSS) && (y < VSE)));
        end
    endtask

    task automatic run_frame(input int f, input int nlines, input int y0);
        cur_f = f;
        for (int y = y0; y < nlines; y++) run_line(y, 0, 0, HT - 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x"}, int'(o_x), 0);
        chk({tag, "_y"}, int'(o_y), 0);
        chk({tag, "_de"}, int'(o_de), 0);
        chk({tag, "_locked"}, int'(o_locked), 0);
        chk({tag, "_line_len"}, int'(o_line_len), 0);
        chk({tag, "_frame_lines"}, int'(o_frame_lines), 0);
        chk({tag, "_err"}, int'(o_err), 0);
    endtask

    initial begin
        i_rst     = 1'b1;
        i_pix_stb = 1'b0;
        i_hs      = 1'b1;
        i_vs      = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        i_rst = 1'b0;

        // Ideal timing: lock at the third VS edge (frame 2, line 9, pixel 0)
        run_frame(0, VT, 0);
        run_frame(1, VT, 0);
        chk("f1_locked", int'(o_locked), 0);
        chk("f1_line_len", int'(o_line_len), 24);
        chk("f1_frame_lines", int'(o_frame_lines), 12);
        run_frame(2, VT, 0);
        chk("lock_pos_a", lock_pos, 20900);
        de_cnt = 0;
        run_frame(3, VT, 0);
        chk("de_per_frame", de_cnt, HA * VA);
        chk("err_none_a", err_cycles, 0);

        // HS leading edge late by one strobe on line 3 of frame 4
        cur_f = 4;
        for (int y = 0; y < 3; y++) run_line(y, 0, 0, HT - 1);
        run_line(3, 1, 0, HT - 1);
        chk("slip_err", err_cycles, 1);
        chk("slip_locked", int'(o_locked), 0);
        chk("slip_len_long", int'(o_line_len), 25);
        run_line(4, 0, 0, HT - 1);
        chk("slip_len_short", int'(o_line_len), 23);
        run_frame(4, VT, 5);
        run_frame(5, VT, 0);
        run_frame(6, VT, 0);
        chk("lock_pos_b", lock_pos, 60900);
        chk("err_after_relock", err_cycles, 1);

        // HS held idle well past twice a line while locked
        cur_f = 7;
        for (int y = 0; y < 3; y++) run_line(y, 0, 0, HT - 1);
        chk_coord = 1'b0;
        for (int i = 0; i < 60; i++) send_px(1'b1, 1'b1);
        chk("timeout_err", err_cycles, 2);
        chk("timeout_locked", int'(o_locked), 0);
        chk_coord = 1'b1;
        run_frame(8, VT, 0);
        run_frame(9, VT, 0);
        run_frame(10, VT, 0);
        chk("lock_pos_c", lock_pos, 100900);

        // Reset mid-frame while locked, then relock with a short frame in MEASURE
        cur_f = 11;
        for (int y = 0; y < 5; y++) run_line(y, 0, 0, HT - 1);
        chk("pre_reset_locked", int'(o_locked), 1);
        i_rst     = 1'b1;
        i_pix_stb = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        i_rst = 1'b0;
        run_frame(11, VT, 5);
        run_frame(12, VT - 1, 0);
        run_frame(13, VT, 0);
        chk("short_frame_lines", int'(o_frame_lines), 11);
        chk("short_frame_locked", int'(o_locked), 0);
        run_frame(14, VT, 0);
        run_frame(15, VT, 0);
        chk("lock_pos_d", lock_pos, 150900);

        // Strobe held off for 50 cycles while the syncs toggle
        cur_f = 16;
        for (int y = 0; y < 3; y++) run_line(y, 0, 0, HT - 1);
        run_line(3, 0, 0, 4);
        chk("hold_pre_x", int'(o_x), 4);
        chk("hold_pre_y", int'(o_y), 3);
        chk("hold_pre_de", int'(o_de), 1);
        for (int i = 0; i < 50; i++) begin
            i_pix_stb = 1'b0;
            i_hs      = ~i_hs;
            i_vs      = ~i_vs;
            @(negedge clk);
        end
        chk("hold_x", int'(o_x), 4);
        chk("hold_y", int'(o_y), 3);
        chk("hold_locked", int'(o_locked), 1);
        chk("hold_line_len", int'(o_line_len), 24);
        chk("hold_frame_lines", int'(o_frame_lines), 12);
        run_line(3, 0, 5, HT - 1);
        run_frame(16, VT, 4);
        chk("end_locked", int'(o_locked), 1);
        chk("end_err", err_cycles, 2);
        chk("coord_track", coord_bad, 0);
        chk("de_unlocked", de_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
